// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle main control FSM: fetch/decode/execute/memory/writeback sequencing
// with registered Moore outputs and a data-memory ready timeout.
module multicycle_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        memReady,
    output logic        regW,
    output logic        flagUpdate,
    output logic        PCS,
    output logic        pcWrite,
    output logic        irWrite,
    output logic        memRd,
    output logic        memW,
    output logic        adrSrc,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [2:0]  aluControl,
    output logic [1:0]  resultSrc,
    output logic        halted,
    output logic        memErr
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_ADR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_HALTED
    } state_t;

    typedef struct packed {
        logic       regW;
        logic       flagUpdate;
        logic       PCS;
        logic       pcWrite;
        logic       irWrite;
        logic       memRd;
        logic       memW;
        logic       adrSrc;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [2:0] aluControl;
        logic [1:0] resultSrc;
        logic       halted;
    } ctrl_t;

    localparam logic [7:0] LP_LAST = 8'(MEM_TIMEOUT - 1);

    // Outputs are registered from the next state so they line up with r_state.
    function automatic ctrl_t f_ctrl(input state_t s, input logic [3:0] op,
                                     input logic sb);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.irWrite = 1'b1;
                c.pcWrite = 1'b1;
                c.aluSrcB = 2'd2;
            end
            S_EXEC_R: begin
                c.aluSrcA    = 1'b1;
                c.aluControl = (op == 4'h7) ? 3'd1 : op[2:0];
                c.flagUpdate = (op == 4'h7) | sb;
            end
            S_EXEC_I: begin
                c.aluSrcA    = 1'b1;
                c.aluSrcB    = 2'd1;
                c.flagUpdate = sb;
            end
            S_ALU_WB: begin
                c.regW      = 1'b1;
                c.resultSrc = 2'd2;
            end
            S_MEM_ADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'd1;
            end
            S_MEM_RD: begin
                c.memRd  = 1'b1;
                c.adrSrc = 1'b1;
            end
            S_MEM_WR: begin
                c.memW   = 1'b1;
                c.adrSrc = 1'b1;
            end
            S_MEM_WB: begin
                c.regW      = 1'b1;
                c.resultSrc = 2'd1;
            end
            S_BRANCH: begin
                c.aluSrcB = 2'd1;
                c.pcWrite = (op == 4'hB);
                c.PCS     = (op == 4'hC);
            end
            S_HALTED: c.halted = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

    state_t     r_state;
    state_t     w_nxt;
    ctrl_t      r_ctrl;
    logic [7:0] r_cnt;
    logic       r_memErr;
    logic [3:0] w_op;
    logic       w_sb;
    logic       w_wait;
    logic       w_timeout;
    logic       w_unused;

    assign w_op      = instr[15:12];
    assign w_sb      = instr[11];
    assign w_unused  = ^instr[10:0];
    assign w_wait    = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
    assign w_timeout = w_wait && !memReady && (r_cnt == LP_LAST);

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_FETCH:  w_nxt = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    4'h0, 4'h1, 4'h2, 4'h3,
                    4'h4, 4'h5, 4'h6, 4'h7: w_nxt = S_EXEC_R;
                    4'h8:                   w_nxt = S_EXEC_I;
                    4'h9, 4'hA:             w_nxt = S_MEM_ADR;
                    4'hB, 4'hC:             w_nxt = S_BRANCH;
                    4'hE:                   w_nxt = S_HALTED;
                    default:                w_nxt = S_FETCH;
                endcase
            end
            S_EXEC_R:  w_nxt = (w_op == 4'h7) ? S_FETCH : S_ALU_WB;
            S_EXEC_I:  w_nxt = S_ALU_WB;
            S_MEM_ADR: w_nxt = (w_op == 4'h9) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (memReady)       w_nxt = S_MEM_WB;
                else if (w_timeout) w_nxt = S_HALTED;
            end
            S_MEM_WR: begin
                if (memReady)       w_nxt = S_FETCH;
                else if (w_timeout) w_nxt = S_HALTED;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH: w_nxt = S_FETCH;
            S_HALTED: w_nxt = S_HALTED;
            default:  w_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_ctrl   <= f_ctrl(S_FETCH, 4'h0, 1'b0);
            r_cnt    <= 8'd0;
            r_memErr <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_ctrl  <= f_ctrl(w_nxt, w_op, w_sb);
            if (w_timeout) r_memErr <= 1'b1;
            if ((w_nxt == S_MEM_RD || w_nxt == S_MEM_WR) && w_nxt != r_state)
                r_cnt <= 8'd0;
            else if (w_wait && !memReady)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign regW       = r_ctrl.regW;
    assign flagUpdate = r_ctrl.flagUpdate;
    assign PCS        = r_ctrl.PCS;
    assign pcWrite    = r_ctrl.pcWrite;
    assign irWrite    = r_ctrl.irWrite;
    assign memRd      = r_ctrl.memRd;
    assign memW       = r_ctrl.memW;
    assign adrSrc     = r_ctrl.adrSrc;
    assign aluSrcA    = r_ctrl.aluSrcA;
    assign aluSrcB    = r_ctrl.aluSrcB;
    assign aluControl = r_ctrl.aluControl;
    assign resultSrc  = r_ctrl.resultSrc;
    assign halted     = r_ctrl.halted;
    assign memErr     = r_memErr;

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Multicycle main control FSM for the ALU datapath; sits directly upstream of the condition-logic stage.
- Decodes the latched 16-bit instruction and sequences fetch, decode, execute, memory and writeback.
- Produces the raw regW, flagUpdate and PCS strobes that the condition stage qualifies with the stored zero flag, plus the datapath mux selects.
- Handles the data-memory ready handshake with a timeout.

Parameters:
- MEM_TIMEOUT, 15: max cycles waiting on memReady before the memory-error halt; must be 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr  in  16  instruction register contents; opcode instr[15:12], S bit instr[11].
- memReady  in  1  data memory completes access this cycle.
- regW  out  1  raw register-write request.
- flagUpdate  out  1  raw zero-flag register enable.
- PCS  out  1  raw branch request.
- pcWrite  out  1  unconditional PC load.
- irWrite  out  1  instruction register load.
- memRd  out  1  data memory read request.
- memW  out  1  data memory write request.
- adrSrc  out  1  0=PC, 1=ALU result to the memory address.
- aluSrcA  out  1  0=PC, 1=reg A.
- aluSrcB  out  2  0=reg B, 1=imm8 zero-extended, 2=constant 1.
- aluControl  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR.
- resultSrc  out  2  0=ALU out, 1=mem data, 2=ALU result reg.
- halted  out  1  FSM is in HALTED.
- memErr  out  1  sticky memory-timeout error.

Behaviour:
- Opcodes: 0-6 R-type ALU ops in aluControl order; 7 CMP; 8 ADDI; 9 LDR; A STR; B B; C BEQ; D NOP; E HALT; F illegal, treated as NOP.
- States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, HALTED.
- All outputs are Moore, decoded from the registered state (plus the latched opcode for aluControl). Outputs not listed for a state are 0.
- Reset: state=FETCH, wait counter=0, memErr=0. Because FETCH is the reset state, the cycle after reset asserts irWrite, pcWrite, aluSrcA=0, aluSrcB=2, aluControl=0. Reset mid-instruction aborts it with no further strobes.
- FETCH: irWrite=1, pcWrite=1, PC+1 via the ALU. Next state DECODE.
- DECODE: no strobes.
  - Opcodes 0-7 -> EXEC_R.
  - 8 -> EXEC_I.
  - 9, A -> MEM_ADR.
  - B, C -> BRANCH.
  - D, F -> FETCH.
  - E -> HALTED.
- EXEC_R: aluSrcA=1, aluSrcB=0, aluControl=opcode (CMP uses SUB).
  - flagUpdate=1 if opcode=7 or S=1.
  - Next state: FETCH for CMP, else ALU_WB.
- EXEC_I: aluSrcA=1, aluSrcB=1, ADD; flagUpdate=S. Next state ALU_WB.
- ALU_WB: regW=1, resultSrc=2. Next state FETCH.
- MEM_ADR: aluSrcA=1, aluSrcB=1, ADD. Next state: MEM_RD for LDR, MEM_WR for STR.
- MEM_RD: memRd=1, adrSrc=1. Held until memReady, then MEM_WB.
- MEM_WR: memW=1, adrSrc=1. Held until memReady, then FETCH.
  - memW must deassert the cycle after memReady is sampled high.
- MEM_WB: regW=1, resultSrc=1. Next state FETCH.
- Wait counter:
  - Clears on entry to MEM_RD or MEM_WR.
  - Increments each cycle memReady=0 in those states.
  - When the counter reaches MEM_TIMEOUT with memReady still 0, the next state is HALTED and memErr sets.
  - memReady=1 in the same cycle the counter reaches MEM_TIMEOUT completes normally; memReady has priority.
- BRANCH: aluSrcA=0, aluSrcB=1, ADD, resultSrc=0.
  - B: pcWrite=1.
  - BEQ: PCS=1; the condition stage gates it with the zero flag.
  - Next state FETCH.
- HALTED: absorbing until reset; halted=1, all strobes 0; memErr holds its value.
- Cycle counts, with w = number of memReady-low cycles:
  - NOP 2; CMP 3; B/BEQ 3; R-type/ADDI 4.
  - STR 4+w; LDR 5+w.
- Exactly one of regW, flagUpdate, PCS, memW, pcWrite, irWrite may be high in any cycle, except FETCH (irWrite+pcWrite).

Test Plan:
- Reset held 2 cycles, then instr=0x0123 (ADD, S=0) -> FETCH/DECODE/EXEC_R/ALU_WB; regW=1 only in cycle 4; flagUpdate never high; aluControl=0 in EXEC_R.
- instr=0x7000 (CMP) -> flagUpdate=1 in cycle 3 with aluControl=1; regW stays 0; FETCH in cycle 4.
- instr=0x9xxx (LDR), memReady low 3 cycles then high -> memRd high 4 cycles, MEM_WB regW=1 with resultSrc=1; total 8 cycles.
- instr=0xAxxx (STR), memReady held 0 with MEM_TIMEOUT=15 -> memW high 15 cycles, then halted=1, memErr=1, all strobes 0 until reset; reset clears both.
- instr=0xC000 (BEQ) then 0xB000 (B) -> PCS=1, pcWrite=0 in BEQ's cycle 3; pcWrite=1, PCS=0 in B's cycle 3.
- Reset asserted during MEM_RD wait -> next cycle state FETCH, memRd=0, memErr=0; instr=0xE000 -> halted=1 from cycle 3, stays high.
